reduce_stream: RTL and testbench
================================

# reduce_stream

Streaming, parametrised bit-reduction engine. Applies one of four reductions (AND, OR, XOR, XNOR) across every bit of a frame of FRAME words, each WIDTH bits wide, and returns one result bit per frame. A ready/valid handshake on both sides makes it usable between LUT-level datapath blocks in ice40 builds, for example as a parity or check generator on a serialised bus.

## Interface
- WIDTH, 8: bits per input word; ≥1.
- FRAME, 4: words per frame; ≥1; beat counter width is clog2(FRAME), minimum 1.
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous, active-high reset.
- I  input  WIDTH  data word.
- I_VALID  input  1  I holds a valid word.
- I_READY  output  1  block accepts I this cycle.
- MODE  input  2  00 AND, 01 OR, 10 XOR, 11 XNOR; sampled on beat 0 only.
- O  output  1  frame reduction result.
- O_VALID  output  1  O holds an unconsumed result.
- O_READY  input  1  downstream consumes O.
- O_FRAMES  output  8  count of results delivered (O_VALID&&O_READY), wraps 255→0.

## Operation
- A beat is accepted when I_VALID && I_READY.
- Beat counter runs 0..FRAME-1. It increments per accepted beat and wraps to 0 after beat FRAME-1 (the last beat).
- Beat 0: MODE is latched into the frame mode register. Changes to MODE on later beats are ignored.
- Word reduction w:
  - AND: &I.
  - OR: |I.
  - XOR or XNOR: ^I.
- Accumulator acc:
  - Beat 0: acc = w.
  - Later beats: acc = acc op w, where op is AND, OR, or XOR (XNOR mode uses XOR).
- Result on the last beat:
  - AND, OR, XOR: acc.
  - XNOR: ~acc, i.e. the complement of the parity of all WIDTH*FRAME bits. This equals a seed-1 chained XNOR when WIDTH*FRAME is even.
- Output buffer: one entry. O and O_VALID are loaded with the result and O_VALID is set. O_VALID clears when O_READY is high, unless a new result loads in the same cycle, in which case it stays 1 with the new O.
- Backpressure: I_READY = !RESET && (!O_VALID || O_READY). The block also stalls non-last beats, which keeps the rule simple and bounds latency.
- FRAME=1: every beat is both beat 0 and the last beat.
- Reset, including mid-frame:
  - beat counter, acc, and mode register are set to 0;
  - O=0, O_VALID=0, O_FRAMES=0;
  - I_READY is 0 while RESET is high;
  - any partial frame is discarded.

## Timing
- Without REDUCE_PIPE_EN:
  - the result appears registered on O/O_VALID in the cycle after the last beat is accepted (latency 1);
  - sustained throughput is one beat per cycle while O_READY stays high.
- I_READY is combinational from O_VALID, O_READY, and RESET. There is no combinational path from I_VALID to I_READY.
- Simultaneous consume and load: O_FRAMES increments, and O/O_VALID take the new result with no bubble.
- O_FRAMES updates in the cycle after the consume handshake.

## Configuration
- REDUCE_PIPE_EN defined:
  - a register stage (s_w, s_valid, s_last, s_first, s_mode) is inserted between the word reduction and the accumulator;
  - result latency is 2 cycles from acceptance of the last beat;
  - MODE is captured into the stage with beat 0;
  - the stage holds when s_last && O_VALID && !O_READY;
  - I_READY = !RESET && (!s_valid || stage advancing);
  - reset clears s_valid.
- REDUCE_PIPE_EN undefined: no stage register. Latency is 1 as above.
- Functional results are identical in both builds; only latency and the I_READY equation differ.

## Test plan
- WIDTH=8, FRAME=1, MODE=11:
  - I=0x00 → O=1.
  - I=0x01 → O=0.
  - I=0xFF → O=1.
  - Each result appears 1 cycle after acceptance (2 with REDUCE_PIPE_EN).
- FRAME=4, MODE=10, beats 0x01,0x02,0x00,0x00 back-to-back → O=0. Beats 0x01,0x00,0x00,0x00 → O=1. O_FRAMES goes to 2.
- FRAME=4, MODE=00 on beat 0 then MODE=01 on beats 1-3, data 0xFF,0xFF,0x7F,0xFF → O=0 (AND retained). Next frame MODE=01, all 0x00 except 0x10 on beat 2 → O=1.
- Backpressure: O_READY=0 with a result pending → I_READY=0, and I_VALID held high does not advance the beat counter. Raising O_READY → result consumed and the next beat accepted in the same cycle.
- RESET asserted after 2 beats of a FRAME=4 frame, then a full frame 0x03 ×4 in XOR mode → O=0. The discarded partial frame has no effect.
- Random stimulus, 10k beats, random O_READY, all modes, compared against a reference model of all WIDTH*FRAME bits → no mismatches, and O_FRAMES matches the handshake count mod 256.

Source files
------------

// File: rtl/reduce_stream_if.sv
// Handshake bundle for reduce_stream: input word stream in, one-bit frame results out.
`timescale 1ns/1ps
interface reduce_stream_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] i;
    logic             i_valid;
    logic             i_ready;
    logic [1:0]       mode;
    logic             o;
    logic             o_valid;
    logic             o_ready;
    logic [7:0]       o_frames;

    modport master (
        output i, i_valid, mode, o_ready,
        input  i_ready, o, o_valid, o_frames
    );

    modport slave (
        input  i, i_valid, mode, o_ready,
        output i_ready, o, o_valid, o_frames
    );
endinterface

// File: rtl/reduce_stream.sv
// Streaming AND/OR/XOR/XNOR reduction of FRAME words of WIDTH bits to one result bit.
// Define REDUCE_PIPE_EN to insert a register stage between word reduction and accumulator.
`timescale 1ns/1ps
module reduce_stream #(
    parameter int WIDTH = 8,
    parameter int FRAME = 4
) (
    input logic          clk,
    input logic          reset,
    reduce_stream_if.slave bus
);
    localparam int            CW        = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME - 1);
    localparam logic [1:0]    M_AND     = 2'b00;
    localparam logic [1:0]    M_OR      = 2'b01;
    localparam logic [1:0]    M_XNOR    = 2'b11;

    function automatic logic word_reduce(input logic [1:0] m, input logic [WIDTH-1:0] d);
        case (m)
            M_AND:   return &d;
            M_OR:    return |d;
            default: return ^d;
        endcase
    endfunction

    // XNOR mode folds with XOR; the complement is applied once to the final result.
    function automatic logic combine(input logic [1:0] m, input logic a, input logic w);
        case (m)
            M_AND:   return a & w;
            M_OR:    return a | w;
            default: return a ^ w;
        endcase
    endfunction

    logic [CW-1:0] beat;
    logic [1:0]    mode_r;
    logic          acc;
    logic          first_in, last_in, accept, w_in;
    logic [1:0]    mode_in;
    logic          a_valid, a_first, a_last, a_w;
    logic [1:0]    a_mode;
    logic          acc_next, result, load;

    assign first_in = (beat == '0);
    assign last_in  = (beat == LAST_BEAT);
    assign mode_in  = first_in ? bus.mode : mode_r;
    assign w_in     = word_reduce(mode_in, bus.i);
    assign accept   = bus.i_valid && bus.i_ready;

`ifdef REDUCE_PIPE_EN
    logic       s_w, s_valid, s_last, s_first, advance;
    logic [1:0] s_mode;

    // Only a finished frame waiting on a full output buffer blocks the stage.
    assign advance     = !(s_valid && s_last && bus.o_valid && !bus.o_ready);
    assign bus.i_ready = !reset && (!s_valid || advance);

    always_ff @(posedge clk) begin
        if (reset)        s_valid <= 1'b0;
        else if (advance) s_valid <= accept;
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s_w     <= w_in;
            s_last  <= last_in;
            s_first <= first_in;
            s_mode  <= mode_in;
        end
    end

    assign a_valid = s_valid && advance;
    assign a_first = s_first;
    assign a_last  = s_last;
    assign a_w     = s_w;
    assign a_mode  = s_mode;
`else
    assign bus.i_ready = !reset && (!bus.o_valid || bus.o_ready);
    assign a_valid     = accept;
    assign a_first     = first_in;
    assign a_last      = last_in;
    assign a_w         = w_in;
    assign a_mode      = mode_in;
`endif

    assign acc_next = a_first ? a_w : combine(a_mode, acc, a_w);
    assign result   = (a_mode == M_XNOR) ? ~acc_next : acc_next;
    assign load     = a_valid && a_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            beat   <= '0;
            mode_r <= '0;
        end else if (accept) begin
            beat <= last_in ? '0 : beat + CW'(1);
            if (first_in) mode_r <= bus.mode;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)        acc <= 1'b0;
        else if (a_valid) acc <= acc_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.o        <= 1'b0;
            bus.o_valid  <= 1'b0;
            bus.o_frames <= 8'd0;
        end else begin
            if (bus.o_valid && bus.o_ready) bus.o_frames <= bus.o_frames + 8'd1;
            if (load) begin
                bus.o       <= result;
                bus.o_valid <= 1'b1;
            end else if (bus.o_ready) begin
                bus.o_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_reduce_stream.sv
// Bench for reduce_stream: FRAME=1 vector table, FRAME=4 hand sequences and random traffic vs a popcount model.
`timescale 1ns/1ps
module tb_reduce_stream;
    localparam int W = 8;
`ifdef REDUCE_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reduce_stream_if #(.WIDTH(W)) b1 ();
    reduce_stream_if #(.WIDTH(W)) b4 ();

    reduce_stream #(.WIDTH(W), .FRAME(1)) dut1 (.clk(clk), .reset(rst), .bus(b1));
    reduce_stream #(.WIDTH(W), .FRAME(4)) dut4 (.clk(clk), .reset(rst), .bus(b4));

    int total = 0;
    int bad   = 0;

    logic [7:0] words[$];
    logic [1:0] fmode;
    bit         exp_q[$];
    bit         use_model;
    int         hs_cnt;
    logic       a, h;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] data;
        logic       exp;
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: count ones over every bit of the frame and apply the mode's rule.
    function automatic bit ref_result(input logic [1:0] m, input logic [7:0] ws[$]);
        int ones = 0;
        foreach (ws[k]) for (int b = 0; b < W; b++) ones += int'(ws[k][b]);
        case (m)
            2'b00:   return ones == W * ws.size();
            2'b01:   return ones > 0;
            2'b10:   return (ones % 2) == 1;
            default: return (ones % 2) == 0;
        endcase
    endfunction

    task automatic step4(input logic v, input logic [7:0] d, input logic [1:0] m, input logic r,
                         output logic acc, output logic hs);
        bit e;
        @(negedge clk);
        check("frames4", 32'(b4.o_frames), hs_cnt & 255);
        b4.i_valid = v;
        b4.i       = d;
        b4.mode    = m;
        b4.o_ready = r;
        #1;
`ifndef REDUCE_PIPE_EN
        check("ready4", 32'(b4.i_ready), 32'(!b4.o_valid || r));
`endif
        acc = v && b4.i_ready;
        hs  = b4.o_valid && r;
        if (hs) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out4_spurious: got result %0b want none", b4.o);
            end else begin
                e = exp_q.pop_front();
                check("out4", 32'(b4.o), 32'(e));
            end
            hs_cnt++;
        end
        if (acc) begin
            if (words.size() == 0) fmode = m;
            words.push_back(d);
            if (words.size() == 4) begin
                if (use_model) exp_q.push_back(ref_result(fmode, words));
                words.delete();
            end
        end
    endtask

    task automatic rst_seq();
        @(negedge clk);
        rst        = 1'b1;
        b1.i_valid = 1'b0;
        b4.i_valid = 1'b0;
        #1;
        check("rst_ready1", 32'(b1.i_ready), 0);
        check("rst_ready4", 32'(b4.i_ready), 0);
        @(negedge clk);
        #1;
        check("rst_valid4", 32'(b4.o_valid), 0);
        check("rst_o4", 32'(b4.o), 0);
        check("rst_frames4", 32'(b4.o_frames), 0);
        check("rst_valid1", 32'(b1.o_valid), 0);
        check("rst_frames1", 32'(b1.o_frames), 0);
        rst = 1'b0;
        words.delete();
        exp_q.delete();
        hs_cnt = 0;
    endtask

    task automatic send_frame4(input logic [31:0] ds, input logic [1:0] m0, input logic [1:0] mr,
                               input logic expv, input string tag);
        logic ac, hh;
        use_model = 1'b0;
        exp_q.push_back(expv);
        for (int k = 0; k < 4; k++) begin
            step4(1'b1, ds[8*k +: 8], (k == 0) ? m0 : mr, 1'b1, ac, hh);
            check({tag, "_acc"}, 32'(ac), 1);
        end
    endtask

    task automatic drain4();
        logic ac, hh;
        for (int k = 0; k < 8; k++) step4(1'b0, 8'h00, 2'b00, 1'b1, ac, hh);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_beats;
        int steps;
        tbl[0] = '{2'b11, 8'h00, 1'b1};
        tbl[1] = '{2'b11, 8'h01, 1'b0};
        tbl[2] = '{2'b11, 8'hFF, 1'b1};
        tbl[3] = '{2'b00, 8'hFF, 1'b1};
        tbl[4] = '{2'b00, 8'hFE, 1'b0};
        tbl[5] = '{2'b01, 8'h00, 1'b0};
        tbl[6] = '{2'b01, 8'h80, 1'b1};
        tbl[7] = '{2'b10, 8'h03, 1'b0};
        tbl[8] = '{2'b10, 8'h07, 1'b1};

        b1.i = '0; b1.i_valid = 1'b0; b1.mode = '0; b1.o_ready = 1'b1;
        b4.i = '0; b4.i_valid = 1'b0; b4.mode = '0; b4.o_ready = 1'b1;
        use_model = 1'b1;
        hs_cnt    = 0;

        rst_seq();

        // FRAME=1: each word is a whole frame; check latency and value.
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            b1.i       = tbl[j].data;
            b1.mode    = tbl[j].mode;
            b1.i_valid = 1'b1;
            b1.o_ready = 1'b1;
            #1;
            check($sformatf("t1_ready[%0d]", j), 32'(b1.i_ready), 1);
            for (int k = 1; k <= LAT; k++) begin
                if (k == LAT) check($sformatf("t1_early[%0d]", j), 32'(b1.o_valid), 0);
                @(negedge clk);
                b1.i_valid = 1'b0;
                #1;
            end
            check($sformatf("t1_valid[%0d]", j), 32'(b1.o_valid), 1);
            check($sformatf("t1_o[%0d]", j), 32'(b1.o), 32'(tbl[j].exp));
            @(negedge clk);
            #1;
            check($sformatf("t1_drain[%0d]", j), 32'(b1.o_valid), 0);
        end
        check("frames1", 32'(b1.o_frames), 9);

        rst_seq();

        send_frame4(32'h00000201, 2'b10, 2'b10, 1'b0, "xor_a");
        send_frame4(32'h00000001, 2'b10, 2'b10, 1'b1, "xor_b");
        drain4();
        check("frames_two", 32'(b4.o_frames), 2);

        send_frame4(32'hFF7FFFFF, 2'b00, 2'b01, 1'b0, "and_kept");
        send_frame4(32'h00100000, 2'b01, 2'b01, 1'b1, "or_frame");
        drain4();

        // Backpressure: result parked with o_ready low, then consume and accept together.
        use_model = 1'b1;
        for (int k = 0; k < 4; k++) step4(1'b1, 8'hFF, 2'b00, 1'b0, a, h);
        for (int k = 0; k < 5; k++) begin
            step4(1'b1, 8'h0F, 2'b01, 1'b0, a, h);
`ifndef REDUCE_PIPE_EN
            check("bp_hold", 32'(a), 0);
`endif
        end
        check("bp_stall", 32'(a), 0);
        check("bp_pending", 32'(b4.o_valid), 1);
        step4(1'b1, 8'h0F, 2'b01, 1'b1, a, h);
        check("bp_acc", 32'(a), 1);
        check("bp_hs", 32'(h), 1);
        for (int k = 0; k < 8 && words.size() != 0; k++)
            step4(1'b1, 8'($urandom), 2'b01, 1'b1, a, h);
        drain4();

        // Mid-frame reset: the two discarded beats would flip the parity if they leaked.
        use_model = 1'b0;
        step4(1'b1, 8'hFF, 2'b10, 1'b1, a, h);
        step4(1'b1, 8'h01, 2'b10, 1'b1, a, h);
        rst_seq();
        send_frame4(32'h03030303, 2'b10, 2'b10, 1'b0, "after_rst");
        drain4();

        // Random traffic against the model.
        use_model = 1'b1;
        acc_beats = 0;
        steps     = 0;
        while (acc_beats < 10000 && steps < 60000) begin
            step4($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom),
                  $urandom_range(0, 3) != 0, a, h);
            if (a) acc_beats++;
            steps++;
        end
        check("rand_beats_done", 32'(acc_beats >= 10000), 1);
        for (int k = 0; k < 8 && words.size() != 0; k++)
            step4(1'b1, 8'($urandom), 2'($urandom), 1'b1, a, h);
        drain4();
        check("rand_frames", 32'(b4.o_frames), hs_cnt & 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
